// File: rtl/mmio_pkg.sv
// Shared definitions for the LSU-to-MMIO bus path: size/response encodings,
// master FSM states and the strobe/width/alignment helpers.
package mmio_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B,
    ST_ERR
  } lsu_state_e;

  function automatic logic [3:0] size_to_strb(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] size_to_width(input logic [1:0] size);
    case (size)
      SZ_B:    return 32'd8;
      SZ_H:    return 32'd16;
      default: return 32'd32;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of low-aligned raw read data by access size.
module lsu_load_ext
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_B:    data = {{(DATA_W-8){~is_unsigned & raw[7]}}, raw[7:0]};
      SZ_H:    data = {{(DATA_W-16){~is_unsigned & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Turns single LSU load/store requests into AXI-lite-style AR/R or AW/W/B
// transactions, one outstanding at a time, with one response per request.
module lsu_axi_master
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,

  output logic [ADDR_W-1:0] arAddr,
  output logic [31:0]       arWidth,
  output logic              arValid,
  input  logic              arReady,
  input  logic [DATA_W-1:0] rData,
  input  logic              rValid,
  output logic              rReady,

  output logic [ADDR_W-1:0] awAddr,
  output logic [1:0]        awPort,
  output logic              awValid,
  input  logic              awReady,
  output logic [DATA_W-1:0] wData,
  output logic [3:0]        wStrb,
  output logic              wValid,
  input  logic              wReady,
  input  logic [1:0]        bResp,
  input  logic              bValid,
  output logic              bReady
);

  lsu_state_e        state;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              aw_done;
  logic              w_done;
  logic [DATA_W-1:0] ext_data;
  logic              aw_fire;
  logic              w_fire;

  assign awPort    = '0;
  assign req_ready = (state == ST_IDLE) && !reset;
  assign aw_fire   = awValid && awReady;
  assign w_fire    = wValid && wReady;

  lsu_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .raw         (rData),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      size_q     <= '0;
      uns_q      <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      arAddr     <= '0;
      arWidth    <= '0;
      arValid    <= 1'b0;
      rReady     <= 1'b0;
      awAddr     <= '0;
      awValid    <= 1'b0;
      wData      <= '0;
      wStrb      <= '0;
      wValid     <= 1'b0;
      bReady     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            size_q <= req_size;
            uns_q  <= req_unsigned;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state      <= ST_ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_wen) begin
              state   <= ST_AWW;
              awAddr  <= req_addr;
              wData   <= req_wdata;
              wStrb   <= size_to_strb(req_size);
              awValid <= 1'b1;
              wValid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= ST_AR;
              arAddr  <= req_addr;
              arWidth <= size_to_width(req_size);
              arValid <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (arReady) begin
            arValid <= 1'b0;
            state   <= ST_R;
          end
        end
        ST_R: begin
          // rReady rises one cycle after entering R, so the response lands at H+1
          if (rReady && rValid) begin
            rReady     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ext_data;
            state      <= ST_IDLE;
          end else begin
            rReady <= 1'b1;
          end
        end
        ST_AWW: begin
          if (aw_fire) begin
            awValid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wValid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_B;
          end
        end
        ST_B: begin
          if (bReady && bValid) begin
            bReady     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= (bResp != RESP_OKAY);
            resp_rdata <= '0;
            state      <= ST_IDLE;
          end else begin
            bReady <= 1'b1;
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed self-checking bench for lsu_axi_master with a scripted AXI-lite slave.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] arAddr, arWidth, rData, awAddr, wData;
  logic        arValid, arReady, rValid, rReady;
  logic [1:0]  awPort, bResp;
  logic        awValid, awReady, wValid, wReady, bValid, bReady;
  logic [3:0]  wStrb;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_total = 0;

  logic [31:0] o_rdata, o_araddr, o_arwidth, o_awaddr, o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_err, o_rr, o_split;
  int          o_lat, o_resp, o_ar_cyc, o_b_cyc;

  always #5 clk = ~clk;

  always @(posedge clk) if (resp_valid) resp_total <= resp_total + 1;

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .arAddr(arAddr), .arWidth(arWidth), .arValid(arValid), .arReady(arReady),
    .rData(rData), .rValid(rValid), .rReady(rReady),
    .awAddr(awAddr), .awPort(awPort), .awValid(awValid), .awReady(awReady),
    .wData(wData), .wStrb(wStrb), .wValid(wValid), .wReady(wReady),
    .bResp(bResp), .bValid(bValid), .bReady(bReady)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    arReady = 1'b0; rValid = 1'b0; rData = '0;
    awReady = 1'b0; wReady = 1'b0; bValid = 1'b0; bResp = '0;
  endtask

  // One request against a scripted slave; awReady is held off aw_delay cycles.
  task automatic txn(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                     input logic [1:0] bresp, input int aw_delay);
    int cyc;
    int aw_cnt;
    bit done;
    o_rdata = 'x; o_err = 1'bx; o_rr = 1'b0; o_split = 1'b0;
    o_araddr = '0; o_arwidth = '0; o_awaddr = '0; o_wdata = '0; o_wstrb = '0;
    o_lat = -1; o_resp = 0; o_ar_cyc = 0; o_b_cyc = 0;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    cyc = 1; aw_cnt = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      if (resp_valid) begin
        o_rdata = resp_rdata; o_err = resp_err; o_rr = req_ready;
        o_lat = cyc; o_resp++; done = 1'b1;
      end
      if (arValid) begin
        o_ar_cyc++; o_araddr = arAddr; o_arwidth = arWidth;
      end
      arReady = arValid;
      rValid  = rReady;
      rData   = rd;
      wReady  = wValid;
      if (wValid) begin
        o_wdata = wData; o_wstrb = wStrb;
      end
      awReady = awValid && (aw_cnt >= aw_delay);
      if (awValid) begin
        o_awaddr = awAddr;
        aw_cnt++;
      end
      if (awValid && !wValid) o_split = 1'b1;
      bValid = bReady;
      bResp  = bresp;
      if (bReady) o_b_cyc++;
      tick();
      cyc++;
    end
    slave_idle();
    if (resp_valid) o_resp++;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    slave_idle();
    repeat (3) tick();
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_valids", {28'b0, arValid, awValid, wValid, resp_valid}, 32'd0);
    check("rst_addr", arAddr | awAddr | wData | resp_rdata, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("awPort", {30'b0, awPort}, 32'd0);

    // word load
    txn(1'b0, 32'h8000_0004, 2'd2, 1'b0, '0, 32'hDEAD_BEEF, 2'b00, 0);
    check("wl_arwidth", o_arwidth, 32'd32);
    check("wl_araddr", o_araddr, 32'h8000_0004);
    check("wl_rdata", o_rdata, 32'hDEAD_BEEF);
    check("wl_err", {31'b0, o_err}, 32'd0);
    check("wl_latency", o_lat, 32'd4);
    check("wl_resp_count", o_resp, 32'd1);
    check("wl_req_ready_at_resp", {31'b0, o_rr}, 32'd1);

    // byte loads, signed then unsigned
    txn(1'b0, 32'h8000_0013, 2'd0, 1'b0, '0, 32'h0000_0080, 2'b00, 0);
    check("bl_s_rdata", o_rdata, 32'hFFFF_FF80);
    check("bl_s_arwidth", o_arwidth, 32'd8);
    txn(1'b0, 32'h8000_0013, 2'd0, 1'b1, '0, 32'h0000_0080, 2'b00, 0);
    check("bl_u_rdata", o_rdata, 32'h0000_0080);

    // half loads with junk in the upper lanes
    txn(1'b0, 32'h8000_0022, 2'd1, 1'b0, '0, 32'hABCD_8001, 2'b00, 0);
    check("hl_s_rdata", o_rdata, 32'hFFFF_8001);
    check("hl_s_arwidth", o_arwidth, 32'd16);
    txn(1'b0, 32'h8000_0022, 2'd1, 1'b1, '0, 32'hABCD_8001, 2'b00, 0);
    check("hl_u_rdata", o_rdata, 32'h0000_8001);

    // half store, AW accepted three cycles after W
    txn(1'b1, 32'hA000_03F8, 2'd1, 1'b0, 32'h0000_1234, '0, 2'b00, 3);
    check("hs_wstrb", {28'b0, o_wstrb}, 32'h3);
    check("hs_wdata", o_wdata, 32'h0000_1234);
    check("hs_awaddr", o_awaddr, 32'hA000_03F8);
    check("hs_split", {31'b0, o_split}, 32'd1);
    check("hs_b_cycles", o_b_cyc, 32'd1);
    check("hs_err", {31'b0, o_err}, 32'd0);
    check("hs_rdata", o_rdata, 32'd0);
    check("hs_latency", o_lat, 32'd7);
    check("hs_resp_count", o_resp, 32'd1);

    // word store with SLVERR
    txn(1'b1, 32'hA000_0100, 2'd2, 1'b0, 32'hCAFE_F00D, '0, 2'b10, 0);
    check("ws_err", {31'b0, o_err}, 32'd1);
    check("ws_wstrb", {28'b0, o_wstrb}, 32'hF);
    check("ws_wdata", o_wdata, 32'hCAFE_F00D);
    check("ws_latency", o_lat, 32'd4);

    // misaligned word load
    txn(1'b0, 32'h8000_0002, 2'd2, 1'b0, '0, 32'h1111_1111, 2'b00, 0);
    check("mis_latency", o_lat, 32'd1);
    check("mis_err", {31'b0, o_err}, 32'd1);
    check("mis_rdata", o_rdata, 32'd0);
    check("mis_no_ar", o_ar_cyc, 32'd0);
    check("mis_resp_count", o_resp, 32'd1);
    check("mis_req_ready_after", {31'b0, req_ready}, 32'd1);

    // reset while waiting in R
    begin
      int snap;
      snap = resp_total;
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0040; req_size = 2'd2;
      tick();
      req_valid = 1'b0;
      arReady = 1'b1;
      tick();
      arReady = 1'b0;
      tick();
      check("mid_rready", {31'b0, rReady}, 32'd1);
      reset = 1'b1;
      tick();
      check("mid_rst_valids", {26'b0, arValid, rReady, awValid, wValid, bReady, resp_valid}, 32'd0);
      reset = 1'b0;
      tick();
      check("mid_no_resp", resp_total - snap, 32'd0);
      check("mid_req_ready", {31'b0, req_ready}, 32'd1);
    end

    txn(1'b0, 32'h8000_0008, 2'd2, 1'b0, '0, 32'h0BAD_F00D, 2'b00, 0);
    check("after_rst_rdata", o_rdata, 32'h0BAD_F00D);
    check("after_rst_err", {31'b0, o_err}, 32'd0);
    check("after_rst_latency", o_lat, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
